// File: rtl/memwb_pkg.sv
// Shared constants and payload layout helpers for the MEM/WB skid stage.
package memwb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  // Payload layout, LSB first: waddr, aludata, rdata, memtoreg, regwrite.
  localparam int unsigned PAYLOAD_W = 2 + 2 * DATA_W_DEF + ADDR_W_DEF;

  function automatic int unsigned payload_w(input int unsigned dw, input int unsigned aw);
    return 2 + 2 * dw + aw;
  endfunction

  function automatic int unsigned off_waddr();
    return 0;
  endfunction

  function automatic int unsigned off_alu(input int unsigned aw);
    return aw;
  endfunction

  function automatic int unsigned off_rdata(input int unsigned dw, input int unsigned aw);
    return aw + dw;
  endfunction

  function automatic int unsigned off_memtoreg(input int unsigned dw, input int unsigned aw);
    return aw + 2 * dw;
  endfunction

  function automatic int unsigned off_regwrite(input int unsigned dw, input int unsigned aw);
    return aw + 2 * dw + 1;
  endfunction

endpackage

// File: rtl/memwb_skid_stage_if.sv
// MEM-side and WB-side handshake bundle for the MEM/WB stage.
interface memwb_skid_stage_if
  import memwb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              valid_i;
  logic              ready_o;
  logic              flush_i;
  logic              regwrite_i;
  logic              memtoreg_i;
  logic [DATA_W-1:0] rdata_i;
  logic [DATA_W-1:0] aludata_i;
  logic [ADDR_W-1:0] waddr_i;
  logic              valid_o;
  logic              ready_i;
  logic              regwrite_o;
  logic              memtoreg_o;
  logic [DATA_W-1:0] rdata_o;
  logic [DATA_W-1:0] aludata_o;
  logic [ADDR_W-1:0] waddr_o;
  logic [DATA_W-1:0] wb_data_o;
  logic              fwd_en_o;
  logic [1:0]        occ_o;

  // Pipeline-control side that drives payloads and consumes results.
  modport master (
    output valid_i, flush_i, regwrite_i, memtoreg_i, rdata_i, aludata_i, waddr_i, ready_i,
    input  ready_o, valid_o, regwrite_o, memtoreg_o, rdata_o, aludata_o, waddr_o,
           wb_data_o, fwd_en_o, occ_o
  );

  // The stage itself.
  modport slave (
    input  valid_i, flush_i, regwrite_i, memtoreg_i, rdata_i, aludata_i, waddr_i, ready_i,
    output ready_o, valid_o, regwrite_o, memtoreg_o, rdata_o, aludata_o, waddr_o,
           wb_data_o, fwd_en_o, occ_o
  );

endinterface

// File: rtl/memwb_entry.sv
// One payload register with valid bit; clear wins over load, invalid means all-zero payload.
module memwb_entry #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         start_i,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic         valid_o,
  output logic [W-1:0] q_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // Entry state: clear zeroes the payload so invalid entries never leak stale fields.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= d_i;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = data_q;

endmodule

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline stage: output entry plus optional skid entry, flush and forwarding tap.
module memwb_skid_stage
  import memwb_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic                clk_i,
  input  logic                start_i,
  memwb_skid_stage_if.slave   bus
);

  localparam int unsigned PW     = payload_w(DATA_W, ADDR_W);
  localparam int unsigned O_WA   = off_waddr();
  localparam int unsigned O_ALU  = off_alu(ADDR_W);
  localparam int unsigned O_RD   = off_rdata(DATA_W, ADDR_W);
  localparam int unsigned O_MTR  = off_memtoreg(DATA_W, ADDR_W);
  localparam int unsigned O_RW   = off_regwrite(DATA_W, ADDR_W);

  logic [PW-1:0] in_payload;
  logic [PW-1:0] out_d;
  logic [PW-1:0] out_q;
  logic          out_valid;
  logic          out_load;
  logic          out_clr;
  logic          skid_valid;
  logic          ready;
  logic          accept;
  logic          out_free;

  assign in_payload = {bus.regwrite_i, bus.memtoreg_i, bus.rdata_i, bus.aludata_i, bus.waddr_i};
  assign out_free   = ~out_valid | bus.ready_i;
  assign accept     = bus.valid_i & ready;

  memwb_entry #(.W(PW)) u_out (
    .clk_i   (clk_i),
    .start_i (start_i),
    .load_i  (out_load),
    .clr_i   (out_clr),
    .d_i     (out_d),
    .valid_o (out_valid),
    .q_o     (out_q)
  );

  if (SKID_EN) begin : g_skid
    logic [PW-1:0] skid_q;
    logic          skid_load;
    logic          skid_clr;

    memwb_entry #(.W(PW)) u_skid (
      .clk_i   (clk_i),
      .start_i (start_i),
      .load_i  (skid_load),
      .clr_i   (skid_clr),
      .d_i     (in_payload),
      .valid_o (skid_valid),
      .q_o     (skid_q)
    );

    // Ready comes straight from the skid flop, so WB backpressure never reaches MEM combinationally.
    assign ready = ~skid_valid;

    // Output entry refills from skid first to keep FIFO order; flush overrides everything.
    always_comb begin
      out_load  = 1'b0;
      out_clr   = 1'b0;
      out_d     = in_payload;
      skid_load = 1'b0;
      skid_clr  = 1'b0;
      if (bus.flush_i) begin
        out_clr  = 1'b1;
        skid_clr = 1'b1;
      end else if (out_free) begin
        skid_clr = 1'b1;
        if (skid_valid) begin
          out_load = 1'b1;
          out_d    = skid_q;
        end else if (accept) begin
          out_load = 1'b1;
        end else begin
          out_clr = 1'b1;
        end
      end else if (accept) begin
        skid_load = 1'b1;
      end
    end
  end else begin : g_noskid
    assign skid_valid = 1'b0;
    assign ready      = out_free;

    // Single hold register: load on accept, drain on consume, flush overrides.
    always_comb begin
      out_d    = in_payload;
      out_load = ~bus.flush_i & accept;
      out_clr  = bus.flush_i | (~accept & out_valid & bus.ready_i);
    end
  end

  assign bus.ready_o    = ready;
  assign bus.valid_o    = out_valid;
  assign bus.regwrite_o = out_q[O_RW];
  assign bus.memtoreg_o = out_q[O_MTR];
  assign bus.rdata_o    = out_q[O_RD +: DATA_W];
  assign bus.aludata_o  = out_q[O_ALU +: DATA_W];
  assign bus.waddr_o    = out_q[O_WA +: ADDR_W];
  assign bus.wb_data_o  = out_q[O_MTR] ? out_q[O_RD +: DATA_W] : out_q[O_ALU +: DATA_W];
  assign bus.fwd_en_o   = out_valid & out_q[O_RW] & (out_q[O_WA +: ADDR_W] != '0);
  assign bus.occ_o      = 2'(out_valid) + 2'(skid_valid);

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Bench for memwb_skid_stage: directed scenarios plus randomized traffic against a FIFO model.
module tb_memwb_skid_stage;

  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic [31:0] rdata;
    logic [31:0] aludata;
    logic [4:0]  waddr;
  } pl_t;

  logic clk_i = 1'b0;
  logic start_i;
  int   checks = 0;
  int   failures = 0;

  always #5 clk_i = ~clk_i;

  memwb_skid_stage_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
  memwb_skid_stage_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();

  memwb_skid_stage #(.DATA_W(32), .ADDR_W(5), .SKID_EN(1'b1)) u_dut1 (
    .clk_i   (clk_i),
    .start_i (start_i),
    .bus     (bus1.slave)
  );

  memwb_skid_stage #(.DATA_W(32), .ADDR_W(5), .SKID_EN(1'b0)) u_dut0 (
    .clk_i   (clk_i),
    .start_i (start_i),
    .bus     (bus0.slave)
  );

  function automatic pl_t mk(input logic rw, input logic mtr, input logic [31:0] rd,
                             input logic [31:0] alu, input logic [4:0] wa);
    pl_t p;
    p.regwrite = rw; p.memtoreg = mtr; p.rdata = rd; p.aludata = alu; p.waddr = wa;
    return p;
  endfunction

  // Expected observable vector for a stage holding 'has' entries headed by p.
  function automatic logic [107:0] exp_vec(input bit has, input pl_t p, input bit rdy, input int occ);
    pl_t         h;
    logic [31:0] wb;
    logic        fwd;
    h   = has ? p : '0;
    wb  = h.memtoreg ? h.rdata : h.aludata;
    fwd = has && h.regwrite && (h.waddr != 5'd0);
    return {has, rdy, 2'(occ), h.regwrite, h.memtoreg, h.rdata, h.aludata, h.waddr, wb, fwd};
  endfunction

  task automatic drv1(input logic v, input pl_t p, input logic rdy, input logic fl);
    bus1.valid_i = v; bus1.regwrite_i = p.regwrite; bus1.memtoreg_i = p.memtoreg;
    bus1.rdata_i = p.rdata; bus1.aludata_i = p.aludata; bus1.waddr_i = p.waddr;
    bus1.ready_i = rdy; bus1.flush_i = fl;
  endtask

  task automatic drv0(input logic v, input pl_t p, input logic rdy, input logic fl);
    bus0.valid_i = v; bus0.regwrite_i = p.regwrite; bus0.memtoreg_i = p.memtoreg;
    bus0.rdata_i = p.rdata; bus0.aludata_i = p.aludata; bus0.waddr_i = p.waddr;
    bus0.ready_i = rdy; bus0.flush_i = fl;
  endtask

  task automatic test_reset();
    logic [107:0] got;
    start_i = 1'b0;
    drv1(1'b0, '0, 1'b1, 1'b0);
    drv0(1'b0, '0, 1'b1, 1'b0);
    repeat (3) @(negedge clk_i);
    got = {bus1.valid_o, bus1.ready_o, bus1.occ_o, bus1.regwrite_o, bus1.memtoreg_o, bus1.rdata_o,
           bus1.aludata_o, bus1.waddr_o, bus1.wb_data_o, bus1.fwd_en_o};
    checks++;
    if (got !== exp_vec(1'b0, '0, 1'b1, 0)) begin
      $display("FAIL reset_skid got=%h exp=%h", got, exp_vec(1'b0, '0, 1'b1, 0)); failures++;
    end
    got = {bus0.valid_o, bus0.ready_o, bus0.occ_o, bus0.regwrite_o, bus0.memtoreg_o, bus0.rdata_o,
           bus0.aludata_o, bus0.waddr_o, bus0.wb_data_o, bus0.fwd_en_o};
    checks++;
    if (got !== exp_vec(1'b0, '0, 1'b1, 0)) begin
      $display("FAIL reset_noskid got=%h exp=%h", got, exp_vec(1'b0, '0, 1'b1, 0)); failures++;
    end
    start_i = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] alu [3];
    alu[0] = 32'h11; alu[1] = 32'h22; alu[2] = 32'h33;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (i > 0) begin
        checks++;
        if (bus1.valid_o !== 1'b1 || bus1.wb_data_o !== alu[i-1] || bus1.occ_o !== 2'd1) begin
          $display("FAIL stream_%0d valid=%b wb=%h occ=%0d exp valid=1 wb=%h occ=1",
                   i, bus1.valid_o, bus1.wb_data_o, bus1.occ_o, alu[i-1]);
          failures++;
        end
      end
      if (i < 3) drv1(1'b1, mk(1'b0, 1'b0, 32'h0, alu[i], 5'(i + 1)), 1'b1, 1'b0);
      else       drv1(1'b0, '0, 1'b1, 1'b0);
    end
    @(negedge clk_i);
    checks++;
    if (bus1.valid_o !== 1'b0 || bus1.occ_o !== 2'd0) begin
      $display("FAIL stream_drain valid=%b occ=%0d exp 0/0", bus1.valid_o, bus1.occ_o); failures++;
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk_i);
    drv1(1'b1, mk(1'b1, 1'b0, 32'h0, 32'h44, 5'd4), 1'b0, 1'b0);
    @(negedge clk_i);
    checks++;
    if (bus1.occ_o !== 2'd1 || bus1.waddr_o !== 5'd4 || bus1.ready_o !== 1'b1) begin
      $display("FAIL bp_a occ=%0d waddr=%0d ready=%b exp 1/4/1", bus1.occ_o, bus1.waddr_o, bus1.ready_o);
      failures++;
    end
    drv1(1'b1, mk(1'b1, 1'b0, 32'h0, 32'h55, 5'd5), 1'b0, 1'b0);
    @(negedge clk_i);
    checks++;
    if (bus1.occ_o !== 2'd2 || bus1.ready_o !== 1'b0 || bus1.waddr_o !== 5'd4) begin
      $display("FAIL bp_full occ=%0d ready=%b waddr=%0d exp 2/0/4", bus1.occ_o, bus1.ready_o, bus1.waddr_o);
      failures++;
    end
    drv1(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk_i);
    checks++;
    if (bus1.waddr_o !== 5'd4 || bus1.aludata_o !== 32'h44 || bus1.occ_o !== 2'd2) begin
      $display("FAIL bp_hold waddr=%0d alu=%h occ=%0d exp 4/44/2", bus1.waddr_o, bus1.aludata_o, bus1.occ_o);
      failures++;
    end
    drv1(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk_i);
    checks++;
    if (bus1.waddr_o !== 5'd5 || bus1.occ_o !== 2'd1 || bus1.ready_o !== 1'b1) begin
      $display("FAIL bp_b waddr=%0d occ=%0d ready=%b exp 5/1/1", bus1.waddr_o, bus1.occ_o, bus1.ready_o);
      failures++;
    end
    @(negedge clk_i);
    checks++;
    if (bus1.valid_o !== 1'b0 || bus1.occ_o !== 2'd0) begin
      $display("FAIL bp_drain valid=%b occ=%0d exp 0/0", bus1.valid_o, bus1.occ_o); failures++;
    end
  endtask

  task automatic test_flush();
    @(negedge clk_i);
    drv1(1'b1, mk(1'b1, 1'b1, 32'hA1, 32'h66, 5'd2), 1'b0, 1'b0);
    @(negedge clk_i);
    drv1(1'b1, mk(1'b1, 1'b0, 32'hA2, 32'h67, 5'd3), 1'b0, 1'b0);
    @(negedge clk_i);
    checks++;
    if (bus1.occ_o !== 2'd2) begin
      $display("FAIL flush_fill occ=%0d exp 2", bus1.occ_o); failures++;
    end
    drv1(1'b1, mk(1'b1, 1'b0, 32'hBB, 32'h77, 5'd7), 1'b1, 1'b1);
    @(negedge clk_i);
    checks++;
    if (bus1.valid_o !== 1'b0 || bus1.occ_o !== 2'd0 || bus1.regwrite_o !== 1'b0 ||
        bus1.rdata_o !== 32'h0 || bus1.aludata_o !== 32'h0 || bus1.waddr_o !== 5'd0 ||
        bus1.ready_o !== 1'b1) begin
      $display("FAIL flush_clear valid=%b occ=%0d rw=%b rd=%h alu=%h wa=%0d ready=%b exp all 0, ready 1",
               bus1.valid_o, bus1.occ_o, bus1.regwrite_o, bus1.rdata_o, bus1.aludata_o,
               bus1.waddr_o, bus1.ready_o);
      failures++;
    end
    drv1(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk_i);
    checks++;
    if (bus1.valid_o !== 1'b0 || bus1.waddr_o !== 5'd0) begin
      $display("FAIL flush_discard valid=%b waddr=%0d exp 0/0", bus1.valid_o, bus1.waddr_o); failures++;
    end
  endtask

  task automatic test_forwarding();
    @(negedge clk_i);
    drv1(1'b1, mk(1'b1, 1'b1, 32'hDEAD, 32'h1234, 5'd9), 1'b1, 1'b0);
    @(negedge clk_i);
    checks++;
    if (bus1.fwd_en_o !== 1'b1 || bus1.wb_data_o !== 32'hDEAD) begin
      $display("FAIL fwd_on fwd=%b wb=%h exp 1/dead", bus1.fwd_en_o, bus1.wb_data_o); failures++;
    end
    drv1(1'b1, mk(1'b1, 1'b1, 32'hDEAD, 32'h1234, 5'd0), 1'b1, 1'b0);
    @(negedge clk_i);
    checks++;
    if (bus1.fwd_en_o !== 1'b0 || bus1.valid_o !== 1'b1 || bus1.wb_data_o !== 32'hDEAD) begin
      $display("FAIL fwd_r0 fwd=%b valid=%b wb=%h exp 0/1/dead", bus1.fwd_en_o, bus1.valid_o, bus1.wb_data_o);
      failures++;
    end
    drv1(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk_i);
    checks++;
    if (bus1.fwd_en_o !== 1'b0 || bus1.valid_o !== 1'b0) begin
      $display("FAIL fwd_idle fwd=%b valid=%b exp 0/0", bus1.fwd_en_o, bus1.valid_o); failures++;
    end
  endtask

  task automatic test_noskid();
    @(negedge clk_i);
    drv0(1'b1, mk(1'b1, 1'b0, 32'h0, 32'h600, 5'd6), 1'b0, 1'b0);
    @(negedge clk_i);
    drv0(1'b1, mk(1'b1, 1'b0, 32'h0, 32'h800, 5'd8), 1'b0, 1'b0);
    #1;
    checks++;
    if (bus0.valid_o !== 1'b1 || bus0.ready_o !== 1'b0 || bus0.waddr_o !== 5'd6) begin
      $display("FAIL noskid_stall valid=%b ready=%b waddr=%0d exp 1/0/6", bus0.valid_o, bus0.ready_o, bus0.waddr_o);
      failures++;
    end
    bus0.ready_i = 1'b1;
    #1;
    checks++;
    if (bus0.ready_o !== 1'b1) begin
      $display("FAIL noskid_comb_ready got=%b exp 1", bus0.ready_o); failures++;
    end
    @(negedge clk_i);
    checks++;
    if (bus0.valid_o !== 1'b1 || bus0.waddr_o !== 5'd8 || bus0.occ_o !== 2'd1) begin
      $display("FAIL noskid_load valid=%b waddr=%0d occ=%0d exp 1/8/1", bus0.valid_o, bus0.waddr_o, bus0.occ_o);
      failures++;
    end
    drv0(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk_i);
    checks++;
    if (bus0.valid_o !== 1'b0 || bus0.occ_o !== 2'd0) begin
      $display("FAIL noskid_drain valid=%b occ=%0d exp 0/0", bus0.valid_o, bus0.occ_o); failures++;
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk_i);
    drv1(1'b1, mk(1'b1, 1'b0, 32'h5, 32'hC1, 5'd10), 1'b0, 1'b0);
    @(negedge clk_i);
    drv1(1'b1, mk(1'b1, 1'b0, 32'h6, 32'hC2, 5'd11), 1'b0, 1'b0);
    @(negedge clk_i);
    drv1(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (bus1.occ_o !== 2'd2) begin
      $display("FAIL areset_fill occ=%0d exp 2", bus1.occ_o); failures++;
    end
    #2 start_i = 1'b0;
    #1;
    checks++;
    if (bus1.valid_o !== 1'b0 || bus1.occ_o !== 2'd0 || bus1.ready_o !== 1'b1 ||
        bus1.regwrite_o !== 1'b0 || bus1.aludata_o !== 32'h0 || bus1.waddr_o !== 5'd0) begin
      $display("FAIL areset_now valid=%b occ=%0d ready=%b rw=%b alu=%h wa=%0d exp 0/0/1/0/0/0",
               bus1.valid_o, bus1.occ_o, bus1.ready_o, bus1.regwrite_o, bus1.aludata_o, bus1.waddr_o);
      failures++;
    end
    @(negedge clk_i);
    start_i = 1'b1;
  endtask

  task automatic test_random();
    pl_t          q1[$];
    pl_t          q0[$];
    pl_t          p1, p0, h;
    logic         v1, r1, f1, v0, r0, f0;
    bit           rdy1, rdy0;
    logic [107:0] got, exp;
    start_i = 1'b0;
    drv1(1'b0, '0, 1'b0, 1'b0);
    drv0(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk_i);
    start_i = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_i);
      v1 = ($urandom_range(0, 9) < 6); r1 = ($urandom_range(0, 9) < 5); f1 = ($urandom_range(0, 24) == 0);
      v0 = ($urandom_range(0, 9) < 6); r0 = ($urandom_range(0, 9) < 5); f0 = ($urandom_range(0, 24) == 0);
      p1 = mk(1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom_range(0, 7)));
      p0 = mk(1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom_range(0, 7)));
      drv1(v1, p1, r1, f1);
      drv0(v0, p0, r0, f0);
      #1;
      rdy1 = q1.size() < 2;
      rdy0 = (q0.size() == 0) || r0;
      h    = (q1.size() > 0) ? q1[0] : '0;
      exp  = exp_vec(q1.size() > 0, h, rdy1, q1.size());
      got  = {bus1.valid_o, bus1.ready_o, bus1.occ_o, bus1.regwrite_o, bus1.memtoreg_o, bus1.rdata_o,
              bus1.aludata_o, bus1.waddr_o, bus1.wb_data_o, bus1.fwd_en_o};
      checks++;
      if (got !== exp) begin
        $display("FAIL rand_skid cyc=%0d got=%h exp=%h", n, got, exp); failures++;
      end
      h    = (q0.size() > 0) ? q0[0] : '0;
      exp  = exp_vec(q0.size() > 0, h, rdy0, q0.size());
      got  = {bus0.valid_o, bus0.ready_o, bus0.occ_o, bus0.regwrite_o, bus0.memtoreg_o, bus0.rdata_o,
              bus0.aludata_o, bus0.waddr_o, bus0.wb_data_o, bus0.fwd_en_o};
      checks++;
      if (got !== exp) begin
        $display("FAIL rand_noskid cyc=%0d got=%h exp=%h", n, got, exp); failures++;
      end
      @(posedge clk_i);
      if (f1) q1.delete();
      else begin
        if (q1.size() > 0 && r1) void'(q1.pop_front());
        if (v1 && rdy1) q1.push_back(p1);
      end
      if (f0) q0.delete();
      else begin
        if (q0.size() > 0 && r0) void'(q0.pop_front());
        if (v0 && rdy0) q0.push_back(p0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_forwarding();
    test_noskid();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
